// File: rtl/pipe_pkg.sv
// Shared pipeline widths, the bubble counter reset value and a saturating
// increment helper for the ID/EX stage and its hazard detector.
package pipe_pkg;

    localparam int XLEN   = 32;
    localparam int REGW   = 5;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 32;

    localparam logic [CNT_W-1:0] BUBBLE_CNT_RST = '0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Purely combinational load-use detector: flags an ID instruction that reads
// the destination of a load still sitting in EX.
module hazard_detect #(
    parameter int REGW = pipe_pkg::REGW
) (
    input  logic            valid_ex,
    input  logic            is_load_ex,
    input  logic            rf_we_ex,
    input  logic [REGW-1:0] wR_ex,
    input  logic            valid_id,
    input  logic [REGW-1:0] rR1_id,
    input  logic [REGW-1:0] rR2_id,
    input  logic            flush_ex,
    output logic            hazard,
    output logic            stall
);

    logic src_match;

    always_comb begin
        src_match = (wR_ex == rR1_id) || (wR_ex == rR2_id);
        hazard    = valid_ex & is_load_ex & rf_we_ex & valid_id & src_match;
        // A wrong-path instruction is squashed anyway, so there is nothing to hold.
        stall     = hazard & ~flush_ex;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB-to-ID operand bypass, load-use bubble
// insertion and a saturating count of inserted bubbles.
module id_ex_stage #(
    parameter int XLEN   = pipe_pkg::XLEN,
    parameter int REGW   = pipe_pkg::REGW,
    parameter int CTRL_W = pipe_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_id,
    input  logic [REGW-1:0]   rR1_id,
    input  logic [REGW-1:0]   rR2_id,
    input  logic [XLEN-1:0]   rD1_id,
    input  logic [XLEN-1:0]   rD2_id,
    input  logic [REGW-1:0]   wR_id,
    input  logic              rf_we_id,
    input  logic              is_load_id,
    input  logic [XLEN-1:0]   imm_id,
    input  logic [XLEN-1:0]   pc_id,
    input  logic [CTRL_W-1:0] ctrl_id,
    input  logic [REGW-1:0]   wR_wb,
    input  logic              rf_we_wb,
    input  logic [XLEN-1:0]   wD_wb,
    input  logic              flush_ex,
    output logic              stall_if_id,
    output logic              valid_ex,
    output logic              rf_we_ex,
    output logic              is_load_ex,
    output logic [REGW-1:0]   wR_ex,
    output logic [REGW-1:0]   rR1_ex,
    output logic [REGW-1:0]   rR2_ex,
    output logic [XLEN-1:0]   rs1_ex,
    output logic [XLEN-1:0]   rs2_ex,
    output logic [XLEN-1:0]   imm_ex,
    output logic [XLEN-1:0]   pc_ex,
    output logic [CTRL_W-1:0] ctrl_ex,
    output logic [31:0]       bubble_cnt
);

    import pipe_pkg::*;

    logic            hazard;
    logic            stall_raw;
    logic            bubble;
    logic            bypass1;
    logic            bypass2;
    logic            rf_we_nxt;
    logic [XLEN-1:0] rs1_nxt;
    logic [XLEN-1:0] rs2_nxt;

    hazard_detect #(
        .REGW(REGW)
    ) u_hazard_detect (
        .valid_ex   (valid_ex),
        .is_load_ex (is_load_ex),
        .rf_we_ex   (rf_we_ex),
        .wR_ex      (wR_ex),
        .valid_id   (valid_id),
        .rR1_id     (rR1_id),
        .rR2_id     (rR2_id),
        .flush_ex   (flush_ex),
        .hazard     (hazard),
        .stall      (stall_raw)
    );

    assign stall_if_id = stall_raw & ~rst;

    // The register file does not forward a same-cycle write, so WB is bypassed here.
    always_comb begin
        bypass1   = rf_we_wb && (wR_wb != '0) && (wR_wb == rR1_id);
        bypass2   = rf_we_wb && (wR_wb != '0) && (wR_wb == rR2_id);
        bubble    = hazard | flush_ex | ~valid_id;
        rf_we_nxt = rf_we_id & valid_id & (wR_id != '0);

        rs1_nxt = rD1_id;
        if (rR1_id == '0) begin
            rs1_nxt = '0;
        end else if (bypass1) begin
            rs1_nxt = wD_wb;
        end

        rs2_nxt = rD2_id;
        if (rR2_id == '0) begin
            rs2_nxt = '0;
        end else if (bypass2) begin
            rs2_nxt = wD_wb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            valid_ex   <= 1'b0;
            rf_we_ex   <= 1'b0;
            is_load_ex <= 1'b0;
            wR_ex      <= '0;
            rR1_ex     <= '0;
            rR2_ex     <= '0;
            rs1_ex     <= '0;
            rs2_ex     <= '0;
            imm_ex     <= '0;
            pc_ex      <= '0;
            ctrl_ex    <= '0;
        end else begin
            valid_ex   <= valid_id;
            rf_we_ex   <= rf_we_nxt;
            is_load_ex <= is_load_id;
            wR_ex      <= wR_id;
            rR1_ex     <= rR1_id;
            rR2_ex     <= rR2_id;
            rs1_ex     <= rs1_nxt;
            rs2_ex     <= rs2_nxt;
            imm_ex     <= imm_id;
            pc_ex      <= pc_id;
            ctrl_ex    <= ctrl_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= BUBBLE_CNT_RST;
        end else if (stall_if_id) begin
            bubble_cnt <= sat_inc(bubble_cnt);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic, all compared against a behavioural model of the EX register.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_id;
    logic [4:0]  rR1_id, rR2_id, wR_id, wR_wb;
    logic [31:0] rD1_id, rD2_id, imm_id, pc_id, wD_wb;
    logic        rf_we_id, is_load_id, rf_we_wb, flush_ex;
    logic [15:0] ctrl_id;
    logic        stall_if_id, valid_ex, rf_we_ex, is_load_ex;
    logic [4:0]  wR_ex, rR1_ex, rR2_ex;
    logic [31:0] rs1_ex, rs2_ex, imm_ex, pc_ex, bubble_cnt;
    logic [15:0] ctrl_ex;

    typedef struct {
        logic        valid;
        logic        rf_we;
        logic        is_load;
        logic [4:0]  wR;
        logic [4:0]  rR1;
        logic [4:0]  rR2;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [15:0] ctrl;
    } ex_t;

    ex_t         expEx;
    ex_t         nxtEx;
    logic [31:0] expCnt;
    logic [31:0] nxtCnt;
    logic        expStall;
    int          nChecks = 0;
    int          nFails  = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .valid_id(valid_id),
        .rR1_id(rR1_id), .rR2_id(rR2_id), .rD1_id(rD1_id), .rD2_id(rD2_id),
        .wR_id(wR_id), .rf_we_id(rf_we_id), .is_load_id(is_load_id),
        .imm_id(imm_id), .pc_id(pc_id), .ctrl_id(ctrl_id),
        .wR_wb(wR_wb), .rf_we_wb(rf_we_wb), .wD_wb(wD_wb), .flush_ex(flush_ex),
        .stall_if_id(stall_if_id), .valid_ex(valid_ex), .rf_we_ex(rf_we_ex),
        .is_load_ex(is_load_ex), .wR_ex(wR_ex), .rR1_ex(rR1_ex), .rR2_ex(rR2_ex),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .imm_ex(imm_ex), .pc_ex(pc_ex),
        .ctrl_ex(ctrl_ex), .bubble_cnt(bubble_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] want);
        nChecks++;
        assert (obs === want) else begin
            nFails++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, want);
        end
    endtask

    // Operand value an instruction should see: x0 is zero, a same-cycle WB write wins over the RF.
    function automatic logic [31:0] operandValue(input logic [4:0] idx, input logic [31:0] rfData);
        if (idx == 5'd0) return 32'd0;
        if (rf_we_wb && wR_wb != 5'd0 && wR_wb == idx) return wD_wb;
        return rfData;
    endfunction

    function automatic logic modelLoadUse();
        return expEx.valid && expEx.is_load && expEx.rf_we && valid_id
               && (expEx.wR == rR1_id || expEx.wR == rR2_id);
    endfunction

    task automatic checkAll();
        checkOutput("valid_ex",   {31'd0, valid_ex},   {31'd0, expEx.valid});
        checkOutput("rf_we_ex",   {31'd0, rf_we_ex},   {31'd0, expEx.rf_we});
        checkOutput("is_load_ex", {31'd0, is_load_ex}, {31'd0, expEx.is_load});
        checkOutput("wR_ex",      {27'd0, wR_ex},      {27'd0, expEx.wR});
        checkOutput("rR1_ex",     {27'd0, rR1_ex},     {27'd0, expEx.rR1});
        checkOutput("rR2_ex",     {27'd0, rR2_ex},     {27'd0, expEx.rR2});
        checkOutput("rs1_ex",     rs1_ex,              expEx.rs1);
        checkOutput("rs2_ex",     rs2_ex,              expEx.rs2);
        checkOutput("imm_ex",     imm_ex,              expEx.imm);
        checkOutput("pc_ex",      pc_ex,               expEx.pc);
        checkOutput("ctrl_ex",    {16'd0, ctrl_ex},    {16'd0, expEx.ctrl});
        checkOutput("bubble_cnt", bubble_cnt,          expCnt);
    endtask

    // Called just after a falling edge with inputs already driven: checks the
    // combinational stall, advances the model over one rising edge, checks EX.
    task automatic applyStimulus();
        logic loadUse;
        #1;
        loadUse  = modelLoadUse();
        expStall = loadUse && !flush_ex && !rst;
        checkOutput("stall_if_id", {31'd0, stall_if_id}, {31'd0, expStall});

        nxtEx  = '{default: '0};
        nxtCnt = expCnt;
        if (!rst && !flush_ex && !loadUse && valid_id) begin
            nxtEx.valid   = 1'b1;
            nxtEx.rf_we   = rf_we_id && (wR_id != 5'd0);
            nxtEx.is_load = is_load_id;
            nxtEx.wR      = wR_id;
            nxtEx.rR1     = rR1_id;
            nxtEx.rR2     = rR2_id;
            nxtEx.rs1     = operandValue(rR1_id, rD1_id);
            nxtEx.rs2     = operandValue(rR2_id, rD2_id);
            nxtEx.imm     = imm_id;
            nxtEx.pc      = pc_id;
            nxtEx.ctrl    = ctrl_id;
        end
        if (rst) nxtCnt = 32'd0;
        else if (expStall && expCnt != 32'hFFFF_FFFF) nxtCnt = expCnt + 32'd1;

        @(posedge clk);
        #1;
        expEx  = nxtEx;
        expCnt = nxtCnt;
        checkAll();
        @(negedge clk);
    endtask

    task automatic setIdle();
        rst = 1'b0; valid_id = 1'b0; flush_ex = 1'b0;
        rR1_id = '0; rR2_id = '0; rD1_id = '0; rD2_id = '0;
        wR_id = '0; rf_we_id = 1'b0; is_load_id = 1'b0;
        imm_id = '0; pc_id = '0; ctrl_id = '0;
        wR_wb = '0; rf_we_wb = 1'b0; wD_wb = '0;
    endtask

    task automatic setId(input logic [4:0] r1, input logic [4:0] r2, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [4:0] wr, input logic we, input logic ld);
        valid_id = 1'b1; rR1_id = r1; rR2_id = r2; rD1_id = d1; rD2_id = d2;
        wR_id = wr; rf_we_id = we; is_load_id = ld;
        imm_id = $urandom; pc_id = $urandom; ctrl_id = 16'($urandom);
    endtask

    initial begin
        expEx  = '{default: '0};
        expCnt = 32'd0;
        setIdle();
        rst = 1'b1;
        @(negedge clk);
        applyStimulus();
        checkOutput("reset valid_ex", {31'd0, valid_ex}, 32'd0);
        checkOutput("reset bubble_cnt", bubble_cnt, 32'd0);

        // Plain pass-through of an RF operand
        setIdle();
        setId(5'd3, 5'd4, 32'h11, 32'h22, 5'd9, 1'b1, 1'b0);
        applyStimulus();
        checkOutput("pass rs1_ex", rs1_ex, 32'h11);
        checkOutput("pass valid_ex", {31'd0, valid_ex}, 32'd1);

        // WB bypass, then the same with a write to x0 which must not bypass
        setId(5'd6, 5'd5, 32'h1, 32'h0, 5'd9, 1'b1, 1'b0);
        rf_we_wb = 1'b1; wR_wb = 5'd5; wD_wb = 32'hDEADBEEF;
        applyStimulus();
        checkOutput("bypass rs2_ex", rs2_ex, 32'hDEADBEEF);
        setId(5'd6, 5'd5, 32'h1, 32'h0, 5'd9, 1'b1, 1'b0);
        rf_we_wb = 1'b1; wR_wb = 5'd0; wD_wb = 32'hDEADBEEF;
        applyStimulus();
        checkOutput("x0 wb rs2_ex", rs2_ex, 32'h0);

        // Load-use: lw x7 then add x8,x7,x1
        setIdle(); rst = 1'b1; applyStimulus(); setIdle();
        setId(5'd2, 5'd0, 32'h100, 32'h0, 5'd7, 1'b1, 1'b1);
        applyStimulus();
        setId(5'd7, 5'd1, 32'h5, 32'h6, 5'd8, 1'b1, 1'b0);
        #1 checkOutput("load-use stall", {31'd0, stall_if_id}, 32'd1);
        applyStimulus();
        checkOutput("load-use bubble valid", {31'd0, valid_ex}, 32'd0);
        checkOutput("load-use bubble_cnt", bubble_cnt, 32'd1);
        #1 checkOutput("re-present no stall", {31'd0, stall_if_id}, 32'd0);
        applyStimulus();
        checkOutput("add in EX valid", {31'd0, valid_ex}, 32'd1);
        checkOutput("add in EX wR", {27'd0, wR_ex}, 32'd8);
        checkOutput("add bubble_cnt", bubble_cnt, 32'd1);

        // Flush and hazard in the same cycle
        setId(5'd2, 5'd0, 32'h100, 32'h0, 5'd7, 1'b1, 1'b1);
        applyStimulus();
        setId(5'd7, 5'd1, 32'h5, 32'h6, 5'd8, 1'b1, 1'b0);
        flush_ex = 1'b1;
        #1 checkOutput("flush stall", {31'd0, stall_if_id}, 32'd0);
        applyStimulus();
        checkOutput("flush valid_ex", {31'd0, valid_ex}, 32'd0);
        checkOutput("flush bubble_cnt", bubble_cnt, 32'd1);
        flush_ex = 1'b0;

        // Reset while a load-use hazard is pending
        setId(5'd2, 5'd0, 32'h100, 32'h0, 5'd7, 1'b1, 1'b1);
        applyStimulus();
        setId(5'd7, 5'd1, 32'h5, 32'h6, 5'd8, 1'b1, 1'b0);
        rst = 1'b1;
        #1 checkOutput("reset stall", {31'd0, stall_if_id}, 32'd0);
        applyStimulus();
        checkOutput("reset mid-stall valid", {31'd0, valid_ex}, 32'd0);
        checkOutput("reset mid-stall cnt", bubble_cnt, 32'd0);
        rst = 1'b0;
        applyStimulus();
        checkOutput("post-reset capture", {31'd0, valid_ex}, 32'd1);

        // A load targeting x0 never stalls its consumer
        setId(5'd2, 5'd0, 32'h100, 32'h0, 5'd0, 1'b1, 1'b1);
        applyStimulus();
        setId(5'd0, 5'd0, 32'h5, 32'h6, 5'd8, 1'b1, 1'b0);
        #1 checkOutput("x0 load no stall", {31'd0, stall_if_id}, 32'd0);
        applyStimulus();

        // Random traffic over a small register set to provoke hazards and bypasses
        for (int i = 0; i < 400; i++) begin
            setIdle();
            setId(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom, $urandom,
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            valid_id = ($urandom_range(0, 7) != 0);
            flush_ex = ($urandom_range(0, 9) == 0);
            rst      = ($urandom_range(0, 49) == 0);
            rf_we_wb = 1'($urandom_range(0, 1));
            wR_wb    = 5'($urandom_range(0, 3));
            wD_wb    = $urandom;
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
